i2c_slave_regfile: RTL and testbench

- Synchronous I2C slave with an internal byte register file.
- Attaches to one upstream port of the I2C hub through split tri-state pins: `_T` (1 = release), `_I` (value driven), `_O` (resolved bus value returned by the hub).
- Decodes 7-bit addressed pointer-write, data-write and data-read transactions with auto-increment.
- Exposes write events and a combinational read port to local logic.

---
 rtl/i2c_slave_regfile.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave exposing a 2^REG_AW x 8-bit register file.
// Inputs are synchronised and glitch-filtered; SDA is only ever pulled low.
// Optional build macro I2C_GEN_CALL_EN: ACK the general-call write address (0x00).
module i2c_slave_regfile #(
    parameter logic [6:0]  SLV_ADDR = 7'h50,
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              scl_T,
    output logic              scl_I,
    input  logic              scl_O,
    output logic              sda_T,
    output logic              sda_I,
    input  logic              sda_O,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [REG_AW-1:0] host_raddr,
    output logic [7:0]        host_rdata,
    output logic              busy
);
    localparam int unsigned       NumRegs = 2 ** REG_AW;
    localparam logic [3:0]        FiltMax = 4'(FILT_LEN - 1);
    localparam logic [REG_AW-1:0] PtrOne  = REG_AW'(1);

    typedef enum logic [2:0] {StIdle, StAddr, StPtr, StWdata, StRdata} state_e;

    logic [1:0]        scl_sync_q, sda_sync_q;
    logic              scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic [3:0]        scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic              scl_upd, sda_upd, scl_rise, scl_fall, start_det, stop_det;
    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d, tx_q, tx_d;
    logic [REG_AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              oe_q, oe_d, ack_q, ack_d, busy_q, busy_d, rw_q, rw_d;
    logic              wr_valid_q, wr_valid_d, reg_we, addr_match;
    logic [7:0]        regs_q [NumRegs];

    // 2-FF synchronisers; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_O};
            sda_sync_q <= {sda_sync_q[0], sda_O};
        end
    end

    // Stability filters: follow the input after FILT_LEN equal differing samples
    always_comb begin
        scl_upd   = (scl_sync_q[1] != scl_f_q) && (scl_cnt_q == FiltMax);
        scl_cnt_d = ((scl_sync_q[1] != scl_f_q) && !scl_upd) ? scl_cnt_q + 4'd1 : 4'd0;
        scl_f_d   = scl_upd ? scl_sync_q[1] : scl_f_q;
        sda_upd   = (sda_sync_q[1] != sda_f_q) && (sda_cnt_q == FiltMax);
        sda_cnt_d = ((sda_sync_q[1] != sda_f_q) && !sda_upd) ? sda_cnt_q + 4'd1 : 4'd0;
        sda_f_d   = sda_upd ? sda_sync_q[1] : sda_f_q;
        scl_rise  = scl_upd & scl_sync_q[1];
        scl_fall  = scl_upd & ~scl_sync_q[1];
        start_det = sda_upd & ~sda_sync_q[1] & scl_f_q & scl_f_d;
        stop_det  = sda_upd & sda_sync_q[1] & scl_f_q & scl_f_d;
    end

    // Filter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_cnt_q <= 4'd0;
            sda_cnt_q <= 4'd0;
        end else begin
            scl_f_q   <= scl_f_d;
            sda_f_q   <= sda_f_d;
            scl_cnt_q <= scl_cnt_d;
            sda_cnt_q <= sda_cnt_d;
        end
    end

    // Address decode of the received address byte
    always_comb begin
        addr_match = (shift_q[7:1] == SLV_ADDR);
`ifdef I2C_GEN_CALL_EN
        if (shift_q == 8'h00) begin
            addr_match = 1'b1;
        end
`endif
    end

    // Protocol FSM: bus conditions first, then bit-level work on SCL edges
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        reg_we     = 1'b0;
        if (start_det || stop_det) begin
            state_d   = start_det ? StAddr : StIdle;
            bit_cnt_d = 4'd0;
            ack_d     = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (state_q != StIdle) begin
            if (scl_rise && !ack_q) begin
                shift_d   = {shift_q[6:0], sda_f_q};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (scl_rise && ack_q && state_q == StRdata && sda_f_q) begin
                // Master NACK ends the read
                state_d = StIdle;
                busy_d  = 1'b0;
                ack_d   = 1'b0;
            end else if (scl_fall) begin
                if (ack_q) begin
                    // End of an ACK slot: release and move on
                    ack_d     = 1'b0;
                    bit_cnt_d = 4'd0;
                    oe_d      = 1'b0;
                    if ((state_q == StAddr && rw_q) || state_q == StRdata) begin
                        state_d = StRdata;
                        tx_d    = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                        ptr_d   = ptr_q + PtrOne;
                    end else if (state_q == StAddr) begin
                        state_d = StPtr;
                    end else if (state_q == StPtr) begin
                        state_d = StWdata;
                    end
                end else if (bit_cnt_q == 4'd8) begin
                    unique case (state_q)
                        StAddr: begin
                            if (addr_match) begin
                                oe_d   = 1'b1;
                                ack_d  = 1'b1;
                                busy_d = 1'b1;
                                rw_d   = shift_q[0];
                            end else begin
                                state_d = StIdle;
                            end
                        end
                        StPtr: begin
                            ptr_d = shift_q[REG_AW-1:0];
                            oe_d  = 1'b1;
                            ack_d = 1'b1;
                        end
                        StWdata: begin
                            reg_we     = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shift_q;
                            ptr_d      = ptr_q + PtrOne;
                            oe_d       = 1'b1;
                            ack_d      = 1'b1;
                        end
                        StRdata: begin
                            // Release for the master's ACK bit
                            oe_d  = 1'b0;
                            ack_d = 1'b1;
                        end
                        default: state_d = StIdle;
                    endcase
                end else if (state_q == StRdata) begin
                    tx_d = {tx_q[6:0], 1'b0};
                    oe_d = ~tx_q[6];
                end
            end
        end
    end

    // Protocol state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Register file storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (reg_we) begin
            regs_q[ptr_q] <= shift_q;
        end
    end

    assign scl_T      = 1'b1;
    assign scl_I      = 1'b1;
    assign sda_T      = ~oe_q;
    assign sda_I      = ~oe_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign host_rdata = regs_q[host_raddr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Testbench for i2c_slave_regfile: bit-banged I2C master, wired-AND SDA,
// scoreboard queues for register-write events and read-back bytes.
module tb_i2c_slave_regfile;
    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       scl_T, scl_I, sda_T, sda_I, wr_valid, busy;
    logic [3:0] wr_addr, host_raddr;
    logic [7:0] wr_data, host_rdata;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_O, sda_O;

    int         checks = 0;
    int         errors = 0;
    int         drive_cnt = 0;
    int         busy_cnt = 0;
    logic [11:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  model[16];

    assign scl_O = m_scl;
    assign sda_O = m_sda & (sda_T | sda_I);

    i2c_slave_regfile #(
        .SLV_ADDR (7'h50),
        .REG_AW   (4),
        .FILT_LEN (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_T      (scl_T),
        .scl_I      (scl_I),
        .scl_O      (scl_O),
        .sda_T      (sda_T),
        .sda_I      (sda_I),
        .sda_O      (sda_O),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Write-event scoreboard consumer and activity counters
    always @(negedge clk) begin
        logic [11:0] exp;
        if (!sda_T) drive_cnt++;
        if (busy) busy_cnt++;
        if (rst_n && wr_valid) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_event unexpected: got addr=%0d data=%02h, required none",
                         wr_addr, wr_data);
            end else begin
                exp = wr_q.pop_front();
                if ({wr_addr, wr_data} !== exp) begin
                    errors++;
                    $display("FAIL wr_event: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             wr_addr, wr_data, exp[11:8], exp[7:0]);
                end
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        model[a] = d;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
        wait_q();
    endtask

    // One master-driven bit; glitch inserts a 2-clk low pulse while SCL is high
    task automatic wbit(input logic b, input logic glitch);
        m_sda = b; wait_q();
        m_scl = 1'b1;
        if (glitch) begin
            repeat (5) @(negedge clk);
            m_scl = 1'b0;
            repeat (2) @(negedge clk);
            m_scl = 1'b1;
            repeat (13) @(negedge clk);
        end else begin
            wait_q(); wait_q();
        end
        m_scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input logic [7:0] glitch,
                              input string name);
        for (int i = 7; i >= 0; i--) wbit(b[i], glitch[i]);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        checks++;
        if (sda_T !== ~exp_ack) begin
            errors++;
            $display("FAIL ack_%s: sda_T=%b, required %b", name, sda_T, ~exp_ack);
        end
        wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic read_byte(output logic [7:0] b, input logic mack);
        b = 8'h00;
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            m_scl = 1'b1; wait_q();
            b[i] = sda_O; wait_q();
            m_scl = 1'b0; wait_q();
        end
        m_sda = mack ? 1'b0 : 1'b1; wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
        m_sda = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({scl_T, scl_I, sda_T, sda_I, wr_valid, busy} !== 6'b111100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 111100",
                     {scl_T, scl_I, sda_T, sda_I, wr_valid, busy});
        end
        checks++;
        if ({wr_addr, wr_data} !== 12'h000) begin
            errors++;
            $display("FAIL reset_wr: got %03h, required 000", {wr_addr, wr_data});
        end
        for (int i = 0; i < 16; i += 5) begin
            host_raddr = 4'(i); #1;
            checks++;
            if (host_rdata !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d: got %02h, required 00", i, host_rdata);
            end
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_write();
        i2c_start();
        write_byte(8'hA0, 1'b1, 8'h00, "w_addr");
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_match: got %b, required 1", busy);
        end
        write_byte(8'h03, 1'b1, 8'h00, "w_ptr");
        expect_write(4'd3, 8'h5A);
        write_byte(8'h5A, 1'b1, 8'h00, "w_d0");
        expect_write(4'd4, 8'hC3);
        write_byte(8'hC3, 1'b1, 8'h00, "w_d1");
        i2c_stop();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_stop: got %b, required 0", busy);
        end
        for (int i = 3; i <= 4; i++) begin
            host_raddr = 4'(i); #1;
            checks++;
            if (host_rdata !== model[i]) begin
                errors++;
                $display("FAIL write_reg%0d: got %02h, required %02h", i, host_rdata, model[i]);
            end
        end
    endtask

    task automatic test_random_read();
        logic [7:0] got, exp;
        i2c_start();
        write_byte(8'hA0, 1'b1, 8'h00, "r_addr_w");
        write_byte(8'h03, 1'b1, 8'h00, "r_ptr");
        i2c_start();
        write_byte(8'hA1, 1'b1, 8'h00, "r_addr_r");
        rd_q.push_back(model[3]);
        rd_q.push_back(model[4]);
        for (int n = 0; n < 2; n++) begin
            read_byte(got, n == 0);
            exp = rd_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL read_byte%0d: got %02h, required %02h", n, got, exp);
            end
        end
        checks++;
        if ({sda_T, busy} !== 2'b10) begin
            errors++;
            $display("FAIL after_nack: sda_T/busy=%b, required 10", {sda_T, busy});
        end
        checks++;
        if (dut.ptr_q !== 4'd5) begin
            errors++;
            $display("FAIL read_ptr: got %0d, required 5", dut.ptr_q);
        end
        i2c_stop();
    endtask

    task automatic test_wrong_addr();
        int d0, b0;
        d0 = drive_cnt;
        b0 = busy_cnt;
        i2c_start();
        write_byte(8'hA2, 1'b0, 8'h00, "wrong_addr");
        write_byte(8'h00, 1'b0, 8'h00, "wrong_data");
        i2c_stop();
        checks++;
        if (drive_cnt != d0 || busy_cnt != b0) begin
            errors++;
            $display("FAIL wrong_addr_quiet: drive=%0d busy=%0d cycles, required 0 0",
                     drive_cnt - d0, busy_cnt - b0);
        end
    endtask

    task automatic test_wrap();
        i2c_start();
        write_byte(8'hA0, 1'b1, 8'h00, "wrap_addr");
        write_byte(8'h0F, 1'b1, 8'h00, "wrap_ptr");
        expect_write(4'd15, 8'h11);
        write_byte(8'h11, 1'b1, 8'h00, "wrap_d0");
        expect_write(4'd0, 8'h22);
        write_byte(8'h22, 1'b1, 8'h00, "wrap_d1");
        i2c_stop();
        for (int i = 0; i < 16; i += 15) begin
            host_raddr = 4'(i); #1;
            checks++;
            if (host_rdata !== model[i]) begin
                errors++;
                $display("FAIL wrap_reg%0d: got %02h, required %02h", i, host_rdata, model[i]);
            end
        end
    endtask

    task automatic test_glitch();
        i2c_start();
        write_byte(8'hA0, 1'b1, 8'h10, "gl_addr");
        write_byte(8'h07, 1'b1, 8'h24, "gl_ptr");
        expect_write(4'd7, 8'h3C);
        write_byte(8'h3C, 1'b1, 8'h81, "gl_data");
        i2c_stop();
        for (int i = 7; i <= 8; i++) begin
            host_raddr = 4'(i); #1;
            checks++;
            if (host_rdata !== model[i]) begin
                errors++;
                $display("FAIL glitch_reg%0d: got %02h, required %02h", i, host_rdata, model[i]);
            end
        end
    endtask

    task automatic test_start_stop_midbyte();
        logic [7:0] got, exp;
        i2c_start();
        write_byte(8'hA0, 1'b1, 8'h00, "mb_addr0");
        write_byte(8'h09, 1'b1, 8'h00, "mb_ptr0");
        wbit(1'b1, 1'b0); wbit(1'b0, 1'b0); wbit(1'b1, 1'b0);
        i2c_start();
        write_byte(8'hA0, 1'b1, 8'h00, "mb_addr1");
        write_byte(8'h08, 1'b1, 8'h00, "mb_ptr1");
        expect_write(4'd8, 8'h99);
        write_byte(8'h99, 1'b1, 8'h00, "mb_data");
        wbit(1'b1, 1'b0); wbit(1'b1, 1'b0);
        i2c_stop();
        checks++;
        if ({sda_T, busy} !== 2'b10) begin
            errors++;
            $display("FAIL midbyte_stop: sda_T/busy=%b, required 10", {sda_T, busy});
        end
        for (int i = 8; i <= 9; i++) begin
            host_raddr = 4'(i); #1;
            checks++;
            if (host_rdata !== model[i]) begin
                errors++;
                $display("FAIL midbyte_reg%0d: got %02h, required %02h", i, host_rdata, model[i]);
            end
        end
        // Current-address read: pointer must have survived the STOP at 9
        i2c_start();
        write_byte(8'hA1, 1'b1, 8'h00, "mb_addr_r");
        rd_q.push_back(model[9]);
        read_byte(got, 1'b0);
        exp = rd_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL midbyte_read: got %02h, required %02h", got, exp);
        end
        i2c_stop();
    endtask

    task automatic test_reset_mid_read();
        i2c_start();
        write_byte(8'hA0, 1'b1, 8'h00, "rst_addr_w");
        write_byte(8'h03, 1'b1, 8'h00, "rst_ptr");
        i2c_start();
        write_byte(8'hA1, 1'b1, 8'h00, "rst_addr_r");
        checks++;
        if (sda_T !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_drive: sda_T=%b, required 0", sda_T);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sda_T !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: sda_T=%b, required 1", sda_T);
        end
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            host_raddr = 4'(i); #1;
            checks++;
            if (host_rdata !== model[i]) begin
                errors++;
                $display("FAIL rst_reg%0d: got %02h, required %02h", i, host_rdata, model[i]);
            end
        end
        checks++;
        if ({dut.ptr_q, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_ptr_busy: got %b, required 00000", {dut.ptr_q, busy});
        end
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_gen_call();
        logic gc;
`ifdef I2C_GEN_CALL_EN
        gc = 1'b1;
`else
        gc = 1'b0;
`endif
        i2c_start();
        write_byte(8'h00, gc, 8'h00, "gc_addr");
        write_byte(8'h02, gc, 8'h00, "gc_ptr");
        if (gc) expect_write(4'd2, 8'h77);
        write_byte(8'h77, gc, 8'h00, "gc_data");
        i2c_stop();
        host_raddr = 4'd2; #1;
        checks++;
        if (host_rdata !== model[2]) begin
            errors++;
            $display("FAIL gc_reg2: got %02h, required %02h", host_rdata, model[2]);
        end
        i2c_start();
        write_byte(8'h01, 1'b0, 8'h00, "gc_read_addr");
        i2c_stop();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        host_raddr = 4'd0;
        test_reset();
        test_write();
        test_random_read();
        test_wrong_addr();
        test_wrap();
        test_glitch();
        test_start_stop_midbyte();
        test_reset_mid_read();
        test_gen_call();
        repeat (20) @(negedge clk);
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL wr_events_missing: %0d outstanding, required 0", wr_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
